// File: rtl/scan_chain_loader_pkg.sv
// Shared state encoding, CRC constant and serial CRC-8 step for the scan chain loader.
package scan_chain_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      EMIT  = 3'd4
   } state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // MSB-first serial CRC-8: feedback is the outgoing MSB xor the new bit.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/scan_chain_loader_if.sv
// Host-side byte streams of the scan chain loader: shift-in bytes and captured bytes.
interface scan_chain_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/scan_chain_loader_crc8_serial.sv
// One-bit-per-cycle CRC-8 accumulator with synchronous clear and update enable.
module scan_chain_loader_crc8_serial
   import scan_chain_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc
);

   logic [7:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = crc8_next(crc_q, bit_in);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/scan_chain_loader.sv
// Byte-stream to scan-chain swap controller; gates proc_en while the chain is shifted.
// Optional CRC-8 over captured bits (crc_out) when SCAN_CHAIN_LOADER_CRC_EN is defined.
module scan_chain_loader
   import scan_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 2120
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              run,
   scan_chain_loader_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic              scan_enable,
   output logic              scan_in,
   input  logic              scan_out,
   output logic              proc_en,
   input  logic              halt,
   output logic              halted
`ifdef SCAN_CHAIN_LOADER_CRC_EN
   ,
   output logic [7:0]        crc_out
`endif
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       in_byte_q, in_byte_d;
   logic [7:0]       out_byte_q, out_byte_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             se_q, se_d;
   logic             si_q, si_d;
   logic             proc_en_q, proc_en_d;
   logic             halted_q, halted_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      in_byte_d   = in_byte_q;
      out_byte_d  = out_byte_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      se_d        = 1'b0;
      si_d        = si_q;
      proc_en_d   = 1'b0;
      halted_d    = halt;

      unique case (state_q)
         IDLE: begin
            proc_en_d = run;
            if (start) begin
               proc_en_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = PREP;
            end
         end
         PREP: begin
            cnt_d      = '0;
            in_ready_d = 1'b1;
            state_d    = LOAD;
         end
         LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               in_byte_d  = bus.in_data;
               out_byte_d = '0;
               idx_d      = '0;
               in_ready_d = 1'b0;
               se_d       = 1'b1;
               si_d       = bus.in_data[0];
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            // se_q/si_q were set up a cycle early, so this edge is the shift edge for bit idx_q.
            out_byte_d[idx_q] = scan_out;
            cnt_d = cnt_q + CNT_W'(1);
            if (idx_q == 3'd7 || cnt_q == LAST) begin
               out_valid_d = 1'b1;
               state_d     = EMIT;
            end else begin
               idx_d = idx_q + 3'd1;
               se_d  = 1'b1;
               si_d  = in_byte_q[idx_d];
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (cnt_q == LEN) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         in_byte_q   <= '0;
         out_byte_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         se_q        <= 1'b0;
         si_q        <= 1'b0;
         proc_en_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         in_byte_q   <= in_byte_d;
         out_byte_q  <= out_byte_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         se_q        <= se_d;
         si_q        <= si_d;
         proc_en_q   <= proc_en_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_byte_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign scan_enable   = se_q;
   assign scan_in       = si_q;
   assign proc_en       = proc_en_q;
   assign halted        = halted_q;

`ifdef SCAN_CHAIN_LOADER_CRC_EN
   scan_chain_loader_crc8_serial u_crc (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_q == PREP),
      .en     (state_q == SHIFT),
      .bit_in (scan_out),
      .crc    (crc_out)
   );
`endif

endmodule
